// File: rtl/encoder_pkg.sv
// Shared widths, FSM state type and bit helpers for the sequential 8-to-3 encoder.
package encoder_pkg;

   localparam int unsigned VEC_W  = 8;
   localparam int unsigned CODE_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   function automatic logic is_single(input logic [VEC_W-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/lowest_set_8.sv
// Combinational priority search: index of the lowest set bit (bit 0 wins) plus an any-set flag.
module lowest_set_8
   import encoder_pkg::*;
(
   input  logic [VEC_W-1:0]  i_vec,
   output logic [CODE_W-1:0] o_idx,
   output logic              o_any
);

   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      // Walk downwards so the lowest set bit is the last one written.
      for (int i = VEC_W - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = CODE_W'(i);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/encoder_8_to_3_seq.sv
// Handshaked 8-to-3 priority encoder: captures a request vector, then emits codes lowest first.
// ENCODER_DRAIN_EN defined: emit every set bit; undefined: emit only the lowest set bit.
module encoder_8_to_3_seq
   import encoder_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [0:7] D,
   input  logic       enable,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       x,
   output logic       y,
   output logic       z,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last
);

   state_e              r_state;
   logic [VEC_W-1:0]    r_pending;
   logic [VEC_W-1:0]    w_d_vec;
   logic [CODE_W-1:0]   w_idx;
   logic                w_any;
   logic                w_emit;
   logic                w_last;

   // Re-index D so that w_d_vec[i] carries the request for code i.
   always_comb begin
      w_d_vec = '0;
      for (int i = 0; i < VEC_W; i++) begin
         w_d_vec[i] = D[i];
      end
   end

   lowest_set_8 u_lowest_set_8 (
      .i_vec (r_pending),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign w_emit = (r_state == EMIT) && w_any;

`ifdef ENCODER_DRAIN_EN
   assign w_last = w_emit && is_single(r_pending);
`else
   assign w_last = w_emit;
`endif

   // All outputs derive from r_state/r_pending only.
   assign in_ready  = (r_state == IDLE);
   assign out_valid = w_emit;
   assign out_last  = w_last;
   assign {x, y, z} = w_emit ? w_idx : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_pending <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && enable && (w_d_vec != '0)) begin
                  r_pending <= w_d_vec;
                  r_state   <= EMIT;
               end
            end
            EMIT: begin
               if (!w_any) begin
                  r_state <= IDLE;
               end else if (out_ready) begin
                  if (w_last) begin
                     r_pending <= '0;
                     r_state   <= IDLE;
                  end else begin
                     r_pending[w_idx] <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encoder_8_to_3_seq.sv
// Randomized and directed bench for encoder_8_to_3_seq against a queue-based reference model.
module tb_encoder_8_to_3_seq;

   logic       clk;
   logic       rst_n;
   logic [0:7] D;
   logic       enable;
   logic       in_valid;
   logic       in_ready;
   logic       x, y, z;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   int n_checks;
   int n_errors;

`ifdef ENCODER_DRAIN_EN
   localparam bit Drain = 1'b1;
`else
   localparam bit Drain = 1'b0;
`endif

   encoder_8_to_3_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .D         (D),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .z         (z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference decoder for the loopback: code c -> request vector with only bit c set.
   function automatic logic [7:0] decode(input int c);
      return 8'(1 << c);
   endfunction

   // Expected beat sequence: set indices in ascending order, truncated to one without drain.
   function automatic void model(input logic [7:0] d, input logic en, output int q[$]);
      q = {};
      if (en) begin
         for (int i = 0; i < 8; i++) begin
            if (d[i]) q.push_back(i);
         end
      end
      if (!Drain && q.size() > 1) q = q[0:0];
   endfunction

   task automatic drive_d(input logic [7:0] d);
      for (int i = 0; i < 8; i++) D[i] = d[i];
   endtask

   // Offer one vector (d[i] == D[i]); first `hold` beat cycles have out_ready low.
   task automatic run_vector(input string tag, input logic [7:0] d, input logic en,
                             input int stall_pct, input int hold);
      int q[$];
      int cyc;
      model(d, en, q);
      @(negedge clk);
      check({tag, "_ready_before"}, in_ready, 1);
      drive_d(d);
      enable   = en;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble inputs: outputs must not follow them.
      drive_d(8'($urandom));
      enable = 1'($urandom);
      cyc = 0;
      while (q.size() > 0) begin
         if (cyc < hold) out_ready = 1'b0;
         else out_ready = ($urandom_range(99) >= stall_pct);
         @(negedge clk);
         check({tag, "_valid"}, out_valid, 1);
         check({tag, "_code"}, {x, y, z}, q[0]);
         check({tag, "_last"}, out_last, (q.size() == 1));
         check({tag, "_busy"}, in_ready, 0);
         if (out_ready) void'(q.pop_front());
         @(posedge clk);
         #1;
         cyc++;
         if (cyc > 300) begin
            check({tag, "_beat_timeout"}, 0, 1);
            q = {};
         end
      end
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_idle_valid"}, out_valid, 0);
      check({tag, "_idle_ready"}, in_ready, 1);
      check({tag, "_idle_code"}, {x, y, z, out_last}, 0);
      in_valid = 1'b0;
      enable   = 1'b0;
      drive_d(8'h00);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      D         = '0;
      enable    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_code", {x, y, z}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", in_ready, 1);

      // Single request, immediate acceptance.
      run_vector("d5", 8'b0010_0000, 1'b1, 0, 0);
      // Bits 1, 4, 6.
      run_vector("d146", 8'b0101_0010, 1'b1, 0, 0);
      // Discarded transfers.
      run_vector("en0", 8'b0000_1000, 1'b0, 0, 0);
      run_vector("zero", 8'b0000_0000, 1'b1, 0, 0);
      // Bits 0 and 7 with 5 cycles of backpressure.
      run_vector("d07_hold", 8'b1000_0001, 1'b1, 0, 5);

      // Reset in the middle of a three-bit vector.
      @(negedge clk);
      drive_d(8'b0101_0010);
      enable   = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = Drain;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("rstmid_pre_valid", out_valid, 1);
      check("rstmid_pre_code", {x, y, z}, Drain ? 3'd4 : 3'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_async_valid", out_valid, 0);
      check("rstmid_async_code", {x, y, z}, 0);
      @(posedge clk);
      #3;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rstmid_post_valid", out_valid, 0);
         check("rstmid_post_ready", in_ready, 1);
      end
      out_ready = 1'b0;

      // Loopback through a reference decoder over every code.
      for (int c = 0; c < 8; c++) begin
         run_vector("loop", decode(c), 1'b1, 0, 0);
      end

      // Random vectors with random enable and backpressure.
      for (int n = 0; n < 150; n++) begin
         run_vector("rand", 8'($urandom), ($urandom_range(9) != 0), 40, $urandom_range(2));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/encoder_8_to_3_seq.md
ENCODER_8_TO_3_SEQ -- requirements
Module: encoder_8_to_3_seq

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 D  input  [0:7]  request vector; bit D[i] requests code i.
REQ-005 enable  input  1  qualifies D; enable=0 means no requests.
REQ-006 in_valid  input  1  D/enable offered this cycle.
REQ-007 in_ready  output  1  block accepts D/enable this cycle.
REQ-008 x, y, z  output  1 each  encoded index, x=MSB, z=LSB ({x,y,z}=i for D[i]).
REQ-009 out_valid  output  1  x,y,z hold a valid code.
REQ-010 out_ready  input  1  consumer accepts current code.
REQ-011 out_last  output  1  current code is the final one for the captured vector.

Function
REQ-012 SHALL implement two states, IDLE and EMIT, in a registered state variable.
REQ-013 IDLE: in_ready=1, out_valid=0; EMIT: in_ready=0, out_valid=1.
REQ-014 In IDLE, a transfer (in_valid=1) with enable=1 and D nonzero SHALL load D into an 8-bit pending register and enter EMIT next cycle.
REQ-015 A transfer with enable=0 or D all-zero SHALL be consumed, discarded, and leave the block in IDLE with no output beat.
REQ-016 Latency: transfer on edge N SHALL give out_valid=1 from edge N+1.
REQ-017 In EMIT, {x,y,z} SHALL be the index of the lowest-numbered set pending bit (D[0] highest priority).
REQ-018 x,y,z,out_valid,out_last SHALL depend only on registered state; no combinational path from D, enable, in_valid or out_ready.
REQ-019 While out_valid=1 and out_ready=0, x,y,z,out_last SHALL hold stable.
REQ-020 On out_valid=1 and out_ready=1, the block SHALL clear the emitted pending bit.
REQ-021 out_last=1 SHALL hold exactly when the emitted beat is the final beat for the vector (see REQ-026/027).
REQ-022 After the final beat is accepted, the block SHALL return to IDLE; in_ready rises the following cycle; no back-to-back overlap of vectors.
REQ-023 With out_valid=0, x,y,z SHALL be driven 0.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, pending=0, out_valid=0, out_last=0, x=y=z=0, in_ready=1 after reset release.
REQ-025 Reset asserted mid-EMIT SHALL abort the vector; no further beats for it after release.

Configuration
REQ-026 Macro ENCODER_DRAIN_EN defined: every set pending bit SHALL be emitted, one beat per accepted handshake, ascending index; out_last=1 when exactly one pending bit remains.
REQ-027 ENCODER_DRAIN_EN undefined: only the lowest-indexed set bit SHALL be emitted, out_last=1 on every beat, remaining bits discarded on acceptance.

Structure
REQ-028 Shared package encoder_pkg SHALL hold VEC_W=8, CODE_W=3 and the IDLE/EMIT state typedef.
REQ-029 The lowest-set-bit search SHALL be a combinational sub-module lowest_set_8 (8-bit vector in, 3-bit index out, any-set flag out), instantiated once.

Verification
REQ-030 Only D[5] set, enable=1, out_ready=1 -> one beat {x,y,z}=101, out_last=1, in_ready back to 1 two cycles after capture.
REQ-031 D[1],D[4],D[6] set, ENCODER_DRAIN_EN -> beats 001,100,110, out_last only on 110; without macro -> single beat 001, out_last=1.
REQ-032 enable=0 with D[3] set, or D all-zero -> transfer accepted, out_valid stays 0, in_ready stays 1.
REQ-033 D[0],D[7] set, out_ready held 0 for 5 cycles -> 000 held stable, in_ready=0 throughout; then 111 after release (drain build).
REQ-034 rst_n pulsed low during second beat of a three-bit drain -> out_valid=0 asynchronously, no remaining beats, IDLE after release.
REQ-035 Loopback with decoder_3_to_8 over all 8 codes, enable=1 -> each encoded output equals the decoder input code, out_last=1.
